// File: rtl/pn_period_meter.sv
// Measures the recurrence period of an upstream PN generator: captures one state,
// then counts valid samples until that state reappears, tallying ones on seq[0].
module pn_period_meter (
   input  logic        next,
   input  logic        reset,
   input  logic        start,
   input  logic        seq_valid,
   input  logic [3:0]  N,
   input  logic [12:0] seq,
   output logic        busy,
   output logic        done,
   output logic [13:0] period,
   output logic [13:0] ones,
   output logic        maximal,
   output logic        lockup,
   output logic        timeout,
   output logic        bad_n
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  n_q_r;
   logic [12:0] ref_r;
   logic [13:0] cnt_r, ones_acc_r;
   logic        busy_r, done_r, maximal_r, lockup_r, timeout_r, bad_n_r;
   logic [13:0] period_r, ones_r;

   logic [13:0] pow_s, cnt_inc_s, ones_inc_s;
   logic [12:0] mask_s, seq_m_s;
   logic        n_bad_s, match_s, limit_s;

   // Derived quantities of the latched register length and the current sample
   always_comb begin
      pow_s      = 14'd1 << n_q_r;
      mask_s     = pow_s[12:0] - 13'd1;
      seq_m_s    = seq & mask_s;
      cnt_inc_s  = cnt_r + 14'd1;
      ones_inc_s = ones_acc_r + {13'd0, seq[0]};
      match_s    = (seq_m_s == ref_r);
      limit_s    = (cnt_inc_s == pow_s);
      n_bad_s    = (N < 4'd2) || (N > 4'd13);
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s = n_bad_s ? ST_DONE : ST_CAPTURE;
            end else begin
               state_s = state_r;
            end
         end
         ST_CAPTURE: begin
            if (seq_valid) begin
               state_s = (seq_m_s == 13'd0) ? ST_DONE : ST_RUN;
            end else begin
               state_s = ST_CAPTURE;
            end
         end
         ST_RUN: begin
            if (seq_valid && (match_s || limit_s)) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register and status flags, registered from the next state
   always_ff @(posedge next) begin
      if (reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_CAPTURE) || (state_s == ST_RUN);
         done_r  <= (state_s == ST_DONE);
      end
   end

   // Measurement datapath and result registers
   always_ff @(posedge next) begin
      if (reset) begin
         n_q_r      <= 4'd0;
         ref_r      <= 13'd0;
         cnt_r      <= 14'd0;
         ones_acc_r <= 14'd0;
         period_r   <= 14'd0;
         ones_r     <= 14'd0;
         maximal_r  <= 1'b0;
         lockup_r   <= 1'b0;
         timeout_r  <= 1'b0;
         bad_n_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  n_q_r      <= N;
                  ref_r      <= 13'd0;
                  cnt_r      <= 14'd0;
                  ones_acc_r <= 14'd0;
                  period_r   <= 14'd0;
                  ones_r     <= 14'd0;
                  maximal_r  <= 1'b0;
                  lockup_r   <= 1'b0;
                  timeout_r  <= 1'b0;
                  bad_n_r    <= n_bad_s;
               end
            end
            ST_CAPTURE: begin
               if (seq_valid) begin
                  ref_r      <= seq_m_s;
                  cnt_r      <= 14'd0;
                  ones_acc_r <= 14'd0;
                  lockup_r   <= (seq_m_s == 13'd0);
               end
            end
            ST_RUN: begin
               if (seq_valid) begin
                  cnt_r      <= cnt_inc_s;
                  ones_acc_r <= ones_inc_s;
                  // A match on the final allowed sample wins over timeout
                  if (match_s) begin
                     period_r  <= cnt_inc_s;
                     ones_r    <= ones_inc_s;
                     maximal_r <= (cnt_inc_s == (pow_s - 14'd1));
                  end else if (limit_s) begin
                     timeout_r <= 1'b1;
                  end
               end
            end
            default: begin
               n_q_r <= 4'd0;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign period  = period_r;
   assign ones    = ones_r;
   assign maximal = maximal_r;
   assign lockup  = lockup_r;
   assign timeout = timeout_r;
   assign bad_n   = bad_n_r;

endmodule

// File: tb/tb_pn_period_meter.sv
// Randomized self-checking bench for pn_period_meter; an upstream Fibonacci LFSR model
// produces the stream and a recurrence search over its state list predicts the results.
module tb_pn_period_meter;

   logic        next = 1'b0;
   logic        reset, start, seq_valid;
   logic [3:0]  N;
   logic [12:0] seq;
   logic        busy, done, maximal, lockup, timeout, bad_n;
   logic [13:0] period, ones;
   int          checks = 0;
   int          errors = 0;

   pn_period_meter dut (
      .next(next), .reset(reset), .start(start), .seq_valid(seq_valid), .N(N), .seq(seq),
      .busy(busy), .done(done), .period(period), .ones(ones), .maximal(maximal),
      .lockup(lockup), .timeout(timeout), .bad_n(bad_n)
   );

   always #5 next = ~next;

   task automatic tick();
      @(posedge next);
      #1;
   endtask

   // Upstream generator: feedback = parity(state & poly), shifted in at bit n-1
   function automatic logic [12:0] gen_step(input logic [12:0] s, input logic [12:0] poly, input int n);
      logic [12:0] m;
      logic        fb;
      m  = 13'((14'd1 << n) - 14'd1);
      fb = ^(s & poly & m);
      return ((s & m) >> 1) | (13'(fb) << (n - 1));
   endfunction

   // Drives one measurement; abort_at >= 0 pulses reset just before that sample
   task automatic run_measure(input string name, input int n, input logic [12:0] poly,
                              input logic [12:0] init, input bit gate, input int abort_at);
      logic [12:0] st[$];
      logic [12:0] m, junk;
      int          lim, end_k, acc;
      logic [13:0] e_period, e_ones;
      logic        e_max, e_lock, e_to;
      m   = 13'((14'd1 << n) - 14'd1);
      lim = 1 << n;
      st.delete();
      st.push_back(init & m);
      for (int i = 1; i <= lim; i++) st.push_back(gen_step(st[i-1], poly, n));
      e_period = 14'd0; e_ones = 14'd0; e_max = 1'b0; e_to = 1'b0;
      e_lock = (st[0] == 13'd0);
      end_k  = -1;
      acc    = 0;
      if (e_lock) begin
         end_k = 0;
      end else begin
         for (int k = 1; k <= lim; k++) begin
            acc += int'(st[k][0]);
            if (st[k] == st[0]) begin
               end_k = k; e_period = 14'(k); e_ones = 14'(acc); e_max = (k == lim - 1);
               break;
            end
         end
         if (end_k < 0) begin
            end_k = lim; e_to = 1'b1;
         end
      end

      N = 4'(n); start = 1'b1; seq_valid = 1'b0; seq = 13'($urandom);
      tick();
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b10) begin
         errors++;
         $display("FAIL %s start busy/done got %b%b want 10", name, busy, done);
      end

      for (int k = 0; k <= end_k; k++) begin
         if (gate) begin
            for (int j = 0; j < 3 && $urandom_range(0, 1) == 1; j++) begin
               seq_valid = 1'b0; seq = 13'($urandom);
               start = 1'($urandom); N = 4'($urandom);
               tick();
               start = 1'b0;
            end
         end
         if (k == abort_at) begin
            reset = 1'b1; seq_valid = 1'b0;
            tick();
            reset = 1'b0;
            checks++;
            if ({busy, done, period, ones, maximal, lockup, timeout, bad_n} !== 34'd0) begin
               errors++;
               $display("FAIL %s abort_clear got busy=%b done=%b period=%0d ones=%0d flags=%b%b%b%b want all 0",
                        name, busy, done, period, ones, maximal, lockup, timeout, bad_n);
            end
            return;
         end
         junk = 13'($urandom);
         seq_valid = 1'b1; seq = st[k] | (junk & ~m);
         start = 1'($urandom); N = 4'($urandom);
         tick();
         start = 1'b0; seq_valid = 1'b0;
         checks++;
         if ({busy, done} !== ((k == end_k) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL %s sample %0d busy/done got %b%b want %b", name, k, busy, done,
                     (k == end_k) ? 2'b01 : 2'b10);
            if (done === 1'b1) break;
         end
      end

      checks++;
      if ({period, ones, maximal, lockup, timeout, bad_n} !== {e_period, e_ones, e_max, e_lock, e_to, 1'b0}) begin
         errors++;
         $display("FAIL %s results got p=%0d o=%0d m=%b l=%b t=%b b=%b want p=%0d o=%0d m=%b l=%b t=%b b=0",
                  name, period, ones, maximal, lockup, timeout, bad_n, e_period, e_ones, e_max, e_lock, e_to);
      end
      for (int i = 0; i < 4; i++) begin
         seq_valid = 1'($urandom); seq = 13'($urandom);
         tick();
      end
      seq_valid = 1'b0;
      checks++;
      if ({done, busy, period, ones} !== {2'b10, e_period, e_ones}) begin
         errors++;
         $display("FAIL %s hold got done=%b busy=%b p=%0d o=%0d want done=1 busy=0 p=%0d o=%0d",
                  name, done, busy, period, ones, e_period, e_ones);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; seq_valid = 1'b1; N = 4'd4; seq = 13'd1;
      tick();
      tick();
      reset = 1'b0; start = 1'b0; seq_valid = 1'b0;
      checks++;
      if ({busy, done, period, ones, maximal, lockup, timeout, bad_n} !== 34'd0) begin
         errors++;
         $display("FAIL reset got busy=%b done=%b p=%0d o=%0d flags=%b%b%b%b want all 0",
                  busy, done, period, ones, maximal, lockup, timeout, bad_n);
      end
   endtask

   task automatic test_directed();
      run_measure("maximal4", 4, 13'h0003, 13'h0001, 1'b0, -1);
      checks++;
      if ({period, ones, maximal, timeout, lockup} !== {14'd15, 14'd8, 3'b100}) begin
         errors++;
         $display("FAIL maximal4_const got p=%0d o=%0d m=%b want p=15 o=8 m=1", period, ones, maximal);
      end
      run_measure("short5", 4, 13'h000F, 13'h0001, 1'b0, -1);
      checks++;
      if ({period, ones, maximal, timeout} !== {14'd5, 14'd2, 2'b00}) begin
         errors++;
         $display("FAIL short5_const got p=%0d o=%0d m=%b t=%b want p=5 o=2 m=0 t=0", period, ones, maximal, timeout);
      end
      run_measure("lockup", 4, 13'h0003, 13'h0000, 1'b0, -1);
      checks++;
      if ({lockup, period} !== {1'b1, 14'd0}) begin
         errors++;
         $display("FAIL lockup_const got l=%b p=%0d want l=1 p=0", lockup, period);
      end
      run_measure("timeout", 4, 13'h0002, 13'h0001, 1'b0, -1);
      checks++;
      if ({timeout, period, ones} !== {1'b1, 14'd0, 14'd0}) begin
         errors++;
         $display("FAIL timeout_const got t=%b p=%0d o=%0d want t=1 p=0 o=0", timeout, period, ones);
      end
   endtask

   task automatic test_bad_n();
      logic [3:0] bad_list[4] = '{4'd1, 4'd14, 4'd0, 4'd15};
      foreach (bad_list[i]) begin
         N = bad_list[i]; start = 1'b1; seq_valid = 1'b1; seq = 13'($urandom);
         tick();
         start = 1'b0; seq_valid = 1'b0;
         checks++;
         if ({busy, done, bad_n, period, ones, maximal, lockup, timeout} !== {3'b011, 31'd0}) begin
            errors++;
            $display("FAIL bad_n N=%0d got busy=%b done=%b bad=%b p=%0d o=%0d flags=%b%b%b want busy=0 done=1 bad=1 rest 0",
                     bad_list[i], busy, done, bad_n, period, ones, maximal, lockup, timeout);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      run_measure("abort", 4, 13'h0003, 13'h0001, 1'b1, 7);
      run_measure("rerun", 4, 13'h0003, 13'h0001, 1'b1, -1);
      checks++;
      if ({period, ones} !== {14'd15, 14'd8}) begin
         errors++;
         $display("FAIL rerun_const got p=%0d o=%0d want p=15 o=8", period, ones);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         run_measure($sformatf("rand%0d", r), $urandom_range(2, 9), 13'($urandom),
                     13'($urandom), 1'($urandom), -1);
      end
      run_measure("rand13", 13, 13'($urandom), 13'($urandom), 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_bad_n();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
